// File: rtl/spi_peripheral.sv
// SPI mode-0 responder (MSB first). Pins are oversampled through 2-FF
// synchronizers; received and transmitted words use level/strobe handshakes.
module spi_peripheral #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             rx_overrun,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_empty,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    logic             cs_s1_q, cs_s2_q, cs_s3_q;
    logic             sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic             mosi_s1_q, mosi_s2_q;

    logic             cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] load_word_s;

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic [WIDTH-2:0] shift_in_q, shift_in_d;
    logic [WIDTH-2:0] shift_out_q, shift_out_d;
    logic             reload_q, reload_d;
    logic             spi_miso_q, spi_miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic [WIDTH-1:0] tx_reg_q, tx_reg_d;
    logic             tx_empty_q, tx_empty_d;
    logic             busy_q, busy_d;

    // Pin synchronizers; the third stage on cs/sclk provides edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            sclk_s1_q <= 1'b1;
            sclk_s2_q <= 1'b1;
            sclk_s3_q <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= spi_cs;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            sclk_s1_q <= spi_clk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign cs_fall_s   =  cs_s3_q   & ~cs_s2_q;
    assign cs_rise_s   = ~cs_s3_q   &  cs_s2_q;
    assign sclk_rise_s = ~sclk_s3_q &  sclk_s2_q;
    assign sclk_fall_s =  sclk_s3_q & ~sclk_s2_q;

    // Next-state logic for the frame FSM, shifters and both handshakes.
    always_comb begin
        state_d      = state_q;
        bit_count_d  = bit_count_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        reload_d     = reload_q;
        spi_miso_d   = spi_miso_q;
        miso_oe_d    = miso_oe_q;
        rx_data_d    = rx_data_q;
        rx_overrun_d = rx_overrun_q;
        tx_reg_d     = tx_reg_q;
        tx_empty_d   = tx_empty_q;
        busy_d       = ~cs_s2_q;
        word_s       = {shift_in_q, mosi_s2_q};
        load_word_s  = tx_empty_q ? IDLE_WORD : tx_reg_q;

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                spi_miso_d  = 1'b1;
                miso_oe_d   = 1'b0;
                bit_count_d = CNT_ZERO;
                reload_d    = 1'b0;
                if (cs_fall_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cs_rise_s) begin
                    state_d    = ST_IDLE;
                    spi_miso_d = 1'b1;
                    miso_oe_d  = 1'b0;
                end else begin
                    state_d     = ST_SHIFT;
                    spi_miso_d  = load_word_s[WIDTH-1];
                    shift_out_d = load_word_s[WIDTH-2:0];
                    tx_empty_d  = 1'b1;
                    miso_oe_d   = 1'b1;
                    bit_count_d = CNT_ZERO;
                    reload_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    // Partial word is dropped; rx_data keeps its last full word.
                    state_d     = ST_IDLE;
                    spi_miso_d  = 1'b1;
                    miso_oe_d   = 1'b0;
                    bit_count_d = CNT_ZERO;
                    reload_d    = 1'b0;
                end else if (sclk_rise_s) begin
                    shift_in_d = word_s[WIDTH-2:0];
                    if (bit_count_q == LAST_BIT) begin
                        rx_data_d    = word_s;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_overrun_q | (rx_valid_q & ~rx_ack);
                        bit_count_d  = CNT_ZERO;
                        reload_d     = 1'b1;
                    end else begin
                        bit_count_d  = bit_count_q + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    if (reload_q) begin
                        spi_miso_d  = load_word_s[WIDTH-1];
                        shift_out_d = load_word_s[WIDTH-2:0];
                        tx_empty_d  = 1'b1;
                        reload_d    = 1'b0;
                    end else if (bit_count_q != CNT_ZERO) begin
                        spi_miso_d  = shift_out_q[WIDTH-2];
                        shift_out_d = {shift_out_q[WIDTH-3:0], 1'b0};
                    end else begin
                        shift_out_d = shift_out_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                spi_miso_d  = 1'b1;
                miso_oe_d   = 1'b0;
                bit_count_d = CNT_ZERO;
                reload_d    = 1'b0;
            end
        endcase

        // A strobe in the same cycle as a load/reload stays pending for the next word.
        if (tx_load) begin
            tx_reg_d   = tx_data;
            tx_empty_d = 1'b0;
        end else begin
            tx_reg_d   = tx_reg_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_count_q  <= CNT_ZERO;
            shift_in_q   <= {(WIDTH-1){1'b0}};
            shift_out_q  <= {(WIDTH-1){1'b0}};
            reload_q     <= 1'b0;
            spi_miso_q   <= 1'b1;
            miso_oe_q    <= 1'b0;
            rx_data_q    <= {WIDTH{1'b0}};
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_reg_q     <= {WIDTH{1'b0}};
            tx_empty_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_count_q  <= bit_count_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            reload_q     <= reload_d;
            spi_miso_q   <= spi_miso_d;
            miso_oe_q    <= miso_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            tx_reg_q     <= tx_reg_d;
            tx_empty_q   <= tx_empty_d;
            busy_q       <= busy_d;
        end
    end

    assign spi_miso    = spi_miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_empty    = tx_empty_q;
    assign busy        = busy_q;

endmodule
